// File: rtl/rsa4k_pkg.sv
// Shared constants and state encoding for the rsa4k word-serial bridge.
package rsa4k_pkg;

    localparam int WIDTH  = 4096;
    localparam int WORD   = 32;
    localparam int NWORDS = WIDTH / WORD;
    localparam int CNT_W  = $clog2(NWORDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_MSG   = 3'd1,
        LD_EXP   = 3'd2,
        LD_MOD   = 3'd3,
        RUN      = 3'd4,
        OUT      = 3'd5,
        WAIT_LOW = 3'd6
    } state_t;

endpackage

// File: rtl/rsa4k_stream_bridge.sv
// Word-serial front end for the rsa4k core: deserialises message, exponent
// and modulus from a 32-bit stream, runs the go/done handshake, then
// serialises the wide cypher back out least-significant word first.
//
// Handshakes: on both the input (s_*) and output (m_*) sides a word moves on
// a rising edge where valid && ready; the sender holds data stable while
// valid is high and ready is low, and ready/valid from this block are
// registered so nothing combinational runs from inputs to outputs.
module rsa4k_stream_bridge
    import rsa4k_pkg::*;
#(
    parameter int WIDTH = rsa4k_pkg::WIDTH,
    parameter int WORD  = rsa4k_pkg::WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WORD-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WORD-1:0]  m_data,
    output logic             m_last,
    output logic             busy,
    output logic             core_go,
    output logic [WIDTH-1:0] core_message,
    output logic [WIDTH-1:0] core_exponent,
    output logic [WIDTH-1:0] core_modulus,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_cypher,
    output state_t           dbg_state
);

    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int IW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q;
    logic [IW-1:0]   base;
    logic            accept;
    logic            last_beat;
    logic            out_xfer;

    assign accept    = s_valid && s_ready;
    assign out_xfer  = m_valid && m_ready;
    assign last_beat = (cnt_q == LAST);
    assign base      = IW'(cnt_q) * IW'(WORD);
    assign m_data    = sh_q[WORD-1:0];
    assign dbg_state = state_q;

    // Next state and beat counter; the counter restarts at every operand switch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = LD_MSG;
                    cnt_d   = CW'(1);
                end
            end
            LD_MSG: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = LD_EXP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LD_EXP: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = LD_MOD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LD_MOD: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d = OUT;
                    cnt_d   = '0;
                end
            end
            OUT: begin
                if (out_xfer) begin
                    if (last_beat) begin
                        state_d = WAIT_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WAIT_LOW: begin
                // A done still high from the previous run must fall before a new load.
                if (!core_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            core_go <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_ready <= (state_d == IDLE) || (state_d == LD_MSG) ||
                       (state_d == LD_EXP) || (state_d == LD_MOD);
            busy    <= (state_d != IDLE);
            core_go <= (state_d == RUN);
            m_valid <= (state_d == OUT);
            m_last  <= (state_d == OUT) && (cnt_d == LAST);
        end
    end

    // Operand deserialiser: beat k lands in bits [k*WORD +: WORD] of the active operand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_message  <= '0;
            core_exponent <= '0;
            core_modulus  <= '0;
        end else if (accept) begin
            if ((state_q == IDLE) || (state_q == LD_MSG)) begin
                core_message[base +: WORD] <= s_data;
            end
            if (state_q == LD_EXP) begin
                core_exponent[base +: WORD] <= s_data;
            end
            if (state_q == LD_MOD) begin
                core_modulus[base +: WORD] <= s_data;
            end
        end
    end

    // Result shift register: capture cypher on done, shift one word per transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q <= '0;
        end else if ((state_q == RUN) && core_done) begin
            sh_q <= core_cypher;
        end else if ((state_q == OUT) && out_xfer) begin
            sh_q <= {{WORD{1'b0}}, sh_q[WIDTH-1:WORD]};
        end
    end

endmodule

// File: tb/tb_rsa4k_stream_bridge.sv
// Directed bench for rsa4k_stream_bridge with a stand-in core and a result scoreboard.
module tb_rsa4k_stream_bridge;
  import rsa4k_pkg::*;

  localparam int W   = 32;
  localparam int NW  = 128;
  localparam int OPW = 4096;
  localparam int LAT = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W-1:0]     s_data = '0;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic             m_last;
  logic             busy;
  logic             core_go;
  logic [OPW-1:0]   core_message;
  logic [OPW-1:0]   core_exponent;
  logic [OPW-1:0]   core_modulus;
  logic             core_done;
  logic [OPW-1:0]   core_cypher = '0;
  state_t           dbg_state;

  int checks = 0;
  int failures = 0;
  int stalls = 0;
  logic [W:0] exp_q[$];
  logic bp_en = 1'b0;
  int done_hold = 0;
  logic spurious = 1'b0;
  logic done_r = 1'b0;

  assign core_done = done_r | spurious;

  rsa4k_stream_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .core_go       (core_go),
    .core_message  (core_message),
    .core_exponent (core_exponent),
    .core_modulus  (core_modulus),
    .core_done     (core_done),
    .core_cypher   (core_cypher),
    .dbg_state     (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] n);
    logic [63:0] r;
    logic [63:0] x;
    if (n == 0) return 32'd0;
    r = 64'(1) % 64'(n);
    x = 64'(b) % 64'(n);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % 64'(n);
      x = (x * x) % 64'(n);
    end
    return r[31:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stand-in core ----------------
  int lat_cnt = 0;
  int hold_cnt = 0;
  always @(posedge clk) begin
    if (core_go) begin
      hold_cnt <= done_hold;
      if (!done_r) begin
        if (lat_cnt == LAT) begin
          done_r      <= 1'b1;
          core_cypher <= {{(OPW-W){1'b0}},
                          modexp(core_message[W-1:0], core_exponent[W-1:0], core_modulus[W-1:0])};
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end else begin
      lat_cnt <= 0;
      if (done_r) begin
        if (hold_cnt == 0) done_r <= 1'b0;
        else hold_cnt <= hold_cnt - 1;
      end
    end
  end

  // ---------------- sink backpressure ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [OPW-1:0] m, input logic [OPW-1:0] e,
                               input logic [OPW-1:0] n);
    logic [31:0] r;
    r = modexp(m[W-1:0], e[W-1:0], n[W-1:0]);
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back({(k == NW - 1), ((k == 0) ? r : 32'd0)});
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit gaps, output bit ok);
    int g;
    logic rdy;
    ok = 1'b0;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    if (g > 0) begin
      s_valid = 1'b0;
      tick(g);
    end
    s_valid = 1'b1;
    s_data  = d;
    for (int c = 0; c < 200; c++) begin
      rdy = s_ready;
      tick(1);
      if (rdy) begin
        ok = 1'b1;
        return;
      end
      stalls++;
    end
  endtask

  task automatic load_ops(input logic [OPW-1:0] m, input logic [OPW-1:0] e,
                          input logic [OPW-1:0] n, input bit gaps, input int limit);
    logic [OPW-1:0] v;
    bit ok;
    for (int i = 0; i < 3 * NW && i < limit; i++) begin
      case (i / NW)
        0:       v = m;
        1:       v = e;
        default: v = n;
      endcase
      if (i == 3 * NW - 1) check("go_low_before_last_beat", 64'(core_go), 64'd0);
      send_word(v[(i % NW) * W +: W], gaps, ok);
      if (!ok) begin
        check("beat_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      if (!busy && exp_q.size() == 0) return;
      tick(1);
    end
    check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200; c++) begin
      if (core_done) return;
      tick(1);
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic prev_stall;
    logic [W-1:0] prev_data;
    logic [W:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 64'(m_valid), 64'd1);
          check("stall_data_held", 64'(m_data), 64'(prev_data));
        end
        if (!m_valid) check("last_without_valid", 64'(m_last), 64'd0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_data), 64'hdead);
          end else begin
            e = exp_q.pop_front();
            check("m_data", 64'(m_data), 64'(e[W-1:0]));
            check("m_last", 64'(m_last), 64'(e[W]));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [OPW-1:0] pm, pe, pn;

    // Model pins: textbook RSA pair with n=77.
    check("model_8_13_77", 64'(modexp(32'd8, 32'd13, 32'd77)), 64'd50);
    check("model_50_37_77", 64'(modexp(32'd50, 32'd37, 32'd77)), 64'd8);

    // Reset values.
    tick(3);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_go", 64'(core_go), 64'd0);
    check("rst_operands", 64'(|{core_message, core_exponent, core_modulus}), 64'd0);
    reset = 1'b1;
    tick(1);
    check("idle_s_ready", 64'(s_ready), 64'd1);

    // Full-rate load 8/13/77 -> 50.
    push_expected(OPW'(8), OPW'(13), OPW'(77));
    load_ops(OPW'(8), OPW'(13), OPW'(77), 1'b0, 3 * NW);
    check("go_after_last_beat", 64'(core_go), 64'd1);
    check("busy_in_run", 64'(busy), 64'd1);
    check("s_ready_in_run", 64'(s_ready), 64'd0);
    wait_done();
    tick(1);
    check("m_valid_after_done", 64'(m_valid), 64'd1);
    check("go_low_in_out", 64'(core_go), 64'd0);
    check("first_word_50", 64'(m_data), 64'h32);
    wait_idle();

    // Chain 50/37/77 -> 8.
    push_expected(OPW'(50), OPW'(37), OPW'(77));
    load_ops(OPW'(50), OPW'(37), OPW'(77), 1'b0, 3 * NW);
    wait_idle();

    // Input gaps and output backpressure.
    bp_en = 1'b1;
    push_expected(OPW'(8), OPW'(13), OPW'(77));
    load_ops(OPW'(8), OPW'(13), OPW'(77), 1'b1, 3 * NW);
    wait_idle();
    push_expected(OPW'(50), OPW'(37), OPW'(77));
    load_ops(OPW'(50), OPW'(37), OPW'(77), 1'b1, 3 * NW);
    wait_idle();
    bp_en = 1'b0;
    tick(1);

    // Pattern load: word k of each operand carries its own index.
    for (int k = 0; k < NW; k++) begin
      pm[k * W +: W] = 32'(k);
      pe[k * W +: W] = 32'h100 + 32'(k);
      pn[k * W +: W] = 32'h200 + 32'(k);
    end
    stalls = 0;
    push_expected(pm, pe, pn);
    load_ops(pm, pe, pn, 1'b0, 3 * NW);
    check("no_ready_bubbles", 64'(stalls), 64'd0);
    for (int k = 0; k < NW; k++) begin
      check("msg_slice", 64'(core_message[k * W +: W]), 64'(k));
      check("exp_slice", 64'(core_exponent[k * W +: W]), 64'(32'h100 + 32'(k)));
      check("mod_slice", 64'(core_modulus[k * W +: W]), 64'(32'h200 + 32'(k)));
    end
    wait_idle();

    // done held high long after go drops: bridge parks until it falls.
    done_hold = 140;
    push_expected(OPW'(8), OPW'(13), OPW'(77));
    load_ops(OPW'(8), OPW'(13), OPW'(77), 1'b0, 3 * NW);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) tick(1);
    tick(2);
    check("wait_low_entered", 64'(dbg_state), 64'(WAIT_LOW));
    for (int c = 0; c < 200 && core_done; c++) begin
      check("wait_low_busy", 64'(busy), 64'd1);
      check("wait_low_no_ready", 64'(s_ready), 64'd0);
      tick(1);
    end
    tick(2);
    check("after_wait_ready", 64'(s_ready), 64'd1);
    check("after_wait_idle", 64'(busy), 64'd0);
    done_hold = 0;

    // done outside RUN is ignored.
    spurious = 1'b1;
    tick(3);
    check("spurious_busy", 64'(busy), 64'd0);
    check("spurious_m_valid", 64'(m_valid), 64'd0);
    check("spurious_s_ready", 64'(s_ready), 64'd1);
    spurious = 1'b0;
    tick(1);

    // Reset in the middle of the exponent load.
    load_ops(OPW'(8), OPW'(13), OPW'(77), 1'b0, NW + 40);
    reset = 1'b0;
    #1;
    check("rst_ldexp_go", 64'(core_go), 64'd0);
    check("rst_ldexp_busy", 64'(busy), 64'd0);
    check("rst_ldexp_msg_cleared", 64'(|core_message), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst_ldexp_ready", 64'(s_ready), 64'd1);

    // Reset while the core is running.
    load_ops(OPW'(50), OPW'(37), OPW'(77), 1'b0, 3 * NW);
    tick(5);
    check("run_go_before_rst", 64'(core_go), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_run_go", 64'(core_go), 64'd0);
    check("rst_run_busy", 64'(busy), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst_run_ready", 64'(s_ready), 64'd1);

    // Fresh load after the resets.
    push_expected(OPW'(8), OPW'(13), OPW'(77));
    load_ops(OPW'(8), OPW'(13), OPW'(77), 1'b0, 3 * NW);
    wait_idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
